// File: rtl/core_pkg.sv
// Shared fetch-stage definitions: controller states, XLEN, NOP encoding and PC step.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with capture, NOP-inject flush and valid-only kill.
module if_id_reg
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = core_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            capture,
  input  logic            flush,
  input  logic            kill,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic            valid
);

  logic [XLEN-1:0] instr_reg;
  logic [XLEN-1:0] pc_reg;
  logic            valid_reg;

  // flush replaces the instruction with a NOP; kill only drops the valid bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_reg <= NOP;
      pc_reg    <= '0;
      valid_reg <= 1'b0;
    end else if (flush) begin
      instr_reg <= NOP;
      valid_reg <= 1'b0;
    end else if (kill) begin
      valid_reg <= 1'b0;
    end else if (capture) begin
      instr_reg <= instr_in;
      pc_reg    <= pc_in;
      valid_reg <= 1'b1;
    end
  end

  assign instr = instr_reg;
  assign pc    = pc_reg;
  assign valid = valid_reg;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory loader arbiter and fetch sequencer: LOAD owns the write port,
// RUN walks the PC into the IF/ID register, HALT parks until a new load is requested.
module imem_fetch_ctrl
  import core_pkg::*;
#(
  parameter int              DEPTH     = 64,
  parameter int              AW        = 6,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [XLEN-1:0] ld_addr,
  input  logic [XLEN-1:0] ld_data,
  input  logic            ld_last,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_req,
  input  logic            start_load,
  output logic [XLEN-1:0] pc_if,
  output logic [XLEN-1:0] instr_id,
  output logic [XLEN-1:0] pc_id,
  output logic            id_valid,
  output logic            running,
  output logic            fault
);

  localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(DEPTH * 4);

  fetch_state_e    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            fault_reg, fault_next;
  logic            id_capture, id_flush, id_kill;
  logic            ld_addr_ok, fetch_bad;

  assign ld_addr_ok = (ld_addr[1:0] == 2'b00) && (ld_addr < MEM_BYTES);
  assign fetch_bad  = (pc_reg[1:0] != 2'b00) || (pc_reg >= MEM_BYTES);

  // rst_n gates the strobe so no write can slip through while reset is held
  assign ld_ready  = (state_reg == LOAD);
  assign mem_we    = rst_n && ld_ready && ld_valid && ld_addr_ok;
  assign mem_addr  = ld_ready ? ld_addr[AW+1:2] : pc_reg[AW+1:2];
  assign mem_wdata = ld_data;
  assign running   = (state_reg == RUN);
  assign pc_if     = pc_reg;
  assign fault     = fault_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= LOAD;
      pc_reg    <= RESET_PC;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      fault_reg <= fault_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    fault_next = fault_reg;
    id_capture = 1'b0;
    id_flush   = 1'b0;
    id_kill    = 1'b0;
    case (state_reg)
      LOAD: begin
        if (ld_valid) begin
          if (!ld_addr_ok) fault_next = 1'b1;
          if (ld_last) begin
            state_next = RUN;
            pc_next    = RESET_PC;
            id_kill    = 1'b1;
          end
        end
      end
      RUN: begin
        if (halt_req) begin
          state_next = HALT;
          id_flush   = 1'b1;
        end else if (redirect_valid) begin
          pc_next  = redirect_pc;
          id_flush = 1'b1;
        end else if (fetch_bad) begin
          state_next = HALT;
          fault_next = 1'b1;
          id_kill    = 1'b1;
        end else if (!stall) begin
          pc_next    = pc_reg + PC_INC;
          id_capture = 1'b1;
        end
      end
      HALT: begin
        if (start_load) begin
          state_next = LOAD;
          fault_next = 1'b0;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  if_id_reg #(
    .NOP(NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (id_capture),
    .flush   (id_flush),
    .kill    (id_kill),
    .instr_in(mem_rdata),
    .pc_in   (pc_reg),
    .instr   (instr_id),
    .pc      (pc_id),
    .valid   (id_valid)
  );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: a per-cycle reference model plus literal checkpoints.
module tb_imem_fetch_ctrl;

  localparam int DEPTH = 64;
  localparam int MEM_BYTES = DEPTH * 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int M_LOAD = 0;
  localparam int M_RUN = 1;
  localparam int M_HALT = 2;

  localparam logic [31:0] W0 = 32'h0010_0093;
  localparam logic [31:0] W1 = 32'h0020_0113;
  localparam logic [31:0] W2 = 32'h0030_0193;
  localparam logic [31:0] W3 = 32'h0040_0213;
  localparam logic [31:0] W63 = 32'h0050_0293;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        ld_last = 1'b0;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt_req = 1'b0;
  logic        start_load = 1'b0;
  logic [31:0] pc_if, instr_id, pc_id;
  logic        id_valid, running, fault;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imem_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_last(ld_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt_req(halt_req), .start_load(start_load),
    .pc_if(pc_if), .instr_id(instr_id), .pc_id(pc_id), .id_valid(id_valid),
    .running(running), .fault(fault)
  );

  // Instruction memory seen by the DUT: asynchronous read, written only through mem_we
  logic [31:0] imem [DEPTH];
  assign mem_rdata = imem[mem_addr];
  always @(posedge clk) if (mem_we) imem[mem_addr] <= mem_wdata;

  // Reference model: its own memory image, updated from the loader rules rather than mem_we
  logic [31:0] mmem [DEPTH];
  int          m_state;
  logic [31:0] m_pc, m_instr, m_pcid;
  logic        m_valid, m_fault;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      imem[i] = 32'hA000_0000 + 32'(i);
      mmem[i] = 32'hA000_0000 + 32'(i);
    end
  end

  function automatic bit addr_good(input logic [31:0] a);
    return (a % 4 == 0) && (a < MEM_BYTES);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= M_LOAD; m_pc <= 32'd0; m_instr <= NOP; m_pcid <= 32'd0;
      m_valid <= 1'b0; m_fault <= 1'b0;
    end else begin
      case (m_state)
        M_LOAD: if (ld_valid) begin
          if (addr_good(ld_addr)) mmem[ld_addr / 4] <= ld_data;
          else m_fault <= 1'b1;
          if (ld_last) begin
            m_state <= M_RUN; m_pc <= 32'd0; m_valid <= 1'b0;
          end
        end
        M_RUN: begin
          if (halt_req) begin
            m_state <= M_HALT; m_valid <= 1'b0; m_instr <= NOP;
          end else if (redirect_valid) begin
            m_pc <= redirect_pc; m_valid <= 1'b0; m_instr <= NOP;
          end else if (!addr_good(m_pc)) begin
            m_state <= M_HALT; m_fault <= 1'b1; m_valid <= 1'b0;
          end else if (!stall) begin
            m_instr <= mmem[m_pc / 4]; m_pcid <= m_pc; m_valid <= 1'b1; m_pc <= m_pc + 32'd4;
          end
        end
        default: if (start_load) begin
          m_state <= M_LOAD; m_fault <= 1'b0;
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, on the falling edge
  always @(negedge clk) begin
    logic exp_we;
    exp_we = rst_n && (m_state == M_LOAD) && ld_valid && addr_good(ld_addr);
    chk1("cmp_mem_we", mem_we, exp_we);
    chk1("cmp_ld_ready", ld_ready, m_state == M_LOAD);
    chk1("cmp_running", running, m_state == M_RUN);
    chk1("cmp_fault", fault, m_fault);
    chk1("cmp_id_valid", id_valid, m_valid);
    chk("cmp_pc_if", pc_if, m_pc);
    chk("cmp_instr_id", instr_id, m_instr);
    chk("cmp_pc_id", pc_id, m_pcid);
    if (m_state == M_LOAD && ld_valid) begin
      chk("cmp_mem_addr_ld", 32'(mem_addr), ld_addr / 4 % DEPTH);
      chk("cmp_mem_wdata", mem_wdata, ld_data);
    end else if (m_state == M_RUN) begin
      chk("cmp_mem_addr_run", 32'(mem_addr), m_pc / 4 % DEPTH);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d, input logic last,
                           input logic exp_we);
    ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
    #1;
    chk1("lit_load_we", mem_we, exp_we);
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
    $display("[TB] load addr=%h data=%h last=%b we=%b fault=%b", a, d, last, exp_we, fault);
  endtask

  initial begin
    // Reset state
    step(); step();
    chk1("lit_rst_running", running, 1'b0);
    chk1("lit_rst_ld_ready", ld_ready, 1'b1);
    chk("lit_rst_pc_if", pc_if, 32'h0);
    chk("lit_rst_instr", instr_id, NOP);
    chk1("lit_rst_valid", id_valid, 1'b0);
    chk1("lit_rst_fault", fault, 1'b0);
    rst_n = 1'b1;
    $display("[TB] reset released");

    // Load four words and run
    load_word(32'd0, W0, 1'b0, 1'b1);
    load_word(32'd4, W1, 1'b0, 1'b1);
    load_word(32'd8, W2, 1'b0, 1'b1);
    load_word(32'd12, W3, 1'b1, 1'b1);
    chk1("lit_run_rise", running, 1'b1);
    chk1("lit_run_valid0", id_valid, 1'b0);
    chk("lit_run_pc0", pc_if, 32'd0);
    step();
    chk("lit_fetch0_instr", instr_id, W0);
    chk("lit_fetch0_pc", pc_id, 32'd0);
    step();
    chk("lit_fetch1_instr", instr_id, W1);
    chk("lit_fetch1_pc", pc_id, 32'd4);
    chk("lit_fetch1_pcif", pc_if, 32'd8);
    $display("[TB] run: fetched words 0,1 pc_if=%h", pc_if);

    // Stall two cycles at pc_if = 8
    stall = 1'b1;
    step(); step();
    chk("lit_stall_pcif", pc_if, 32'd8);
    chk("lit_stall_instr", instr_id, W1);
    chk("lit_stall_pcid", pc_id, 32'd4);
    stall = 1'b0;
    step();
    chk("lit_unstall_pcid", pc_id, 32'd8);
    chk("lit_unstall_instr", instr_id, W2);
    step();
    chk("lit_fetch3_instr", instr_id, W3);
    $display("[TB] stall/release done pc_id=%h", pc_id);

    // Redirect together with stall
    redirect_valid = 1'b1; redirect_pc = 32'd4; stall = 1'b1;
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    chk("lit_redir_pcif", pc_if, 32'd4);
    chk1("lit_redir_valid", id_valid, 1'b0);
    chk("lit_redir_instr", instr_id, NOP);
    step();
    chk("lit_redir_pcid", pc_id, 32'd4);
    chk("lit_redir_fetch", instr_id, W1);
    $display("[TB] redirect to 4 done");

    // Halt, then back to LOAD
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk1("lit_halt_running", running, 1'b0);
    chk("lit_halt_instr", instr_id, NOP);
    start_load = 1'b1;
    step();
    start_load = 1'b0;
    chk1("lit_reload_ready", ld_ready, 1'b1);
    $display("[TB] halt -> load");

    // Bad loads, then final word at the last in-range address
    load_word(32'd256, 32'h1111_1111, 1'b0, 1'b0);
    chk1("lit_badload_fault", fault, 1'b1);
    load_word(32'd6, 32'h2222_2222, 1'b0, 1'b0);
    load_word(32'd252, W63, 1'b1, 1'b1);
    chk1("lit_fault_sticky", fault, 1'b1);
    chk1("lit_run_again", running, 1'b1);

    // Fetch overrun past the top word
    redirect_valid = 1'b1; redirect_pc = 32'd252;
    step();
    redirect_valid = 1'b0;
    chk("lit_ovr_pcif", pc_if, 32'd252);
    step();
    chk("lit_ovr_word63", instr_id, W63);
    chk("lit_ovr_pc256", pc_if, 32'd256);
    step();
    chk1("lit_ovr_halt", running, 1'b0);
    chk1("lit_ovr_fault", fault, 1'b1);
    chk1("lit_ovr_valid", id_valid, 1'b0);
    ld_valid = 1'b1; ld_addr = 32'd0; ld_data = 32'h3333_3333;
    #1;
    chk1("lit_halt_ignores_ld", mem_we, 1'b0);
    step();
    ld_valid = 1'b0; start_load = 1'b1;
    step();
    start_load = 1'b0;
    chk1("lit_ovr_fault_clr", fault, 1'b0);
    chk1("lit_ovr_ld_ready", ld_ready, 1'b1);
    $display("[TB] overrun halt -> load, fault cleared");

    // Reset mid-RUN between clock edges
    load_word(32'd0, W0, 1'b1, 1'b1);
    step(); step();
    #2;
    rst_n = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'd0; ld_data = 32'h4444_4444;
    #1;
    chk1("lit_arst_we", mem_we, 1'b0);
    chk1("lit_arst_running", running, 1'b0);
    chk1("lit_arst_ld_ready", ld_ready, 1'b1);
    chk("lit_arst_pc_if", pc_if, 32'h0);
    chk("lit_arst_pc_id", pc_id, 32'h0);
    chk("lit_arst_instr", instr_id, NOP);
    chk1("lit_arst_valid", id_valid, 1'b0);
    step();
    ld_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step(); step();
    $display("[TB] async reset mid-run done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Fetch sequencer and loader arbiter for the single-port, asynchronous-read instruction memory.
- After reset it owns the memory write port for program loading, then switches to RUN and sequences the PC.
- In RUN it drives the IF/ID pipeline register, honouring hazard-unit stalls and branch/jump redirects.
- Sits between the instruction memory, the hazard unit and the EX-stage branch resolution.

Parameters:
- DEPTH, 64, instruction memory depth in 32-bit words (power of 2).
- AW, 6, word-index width, equal to log2(DEPTH).
- RESET_PC, 32'h0000_0000, first fetch byte address after a load completes.
- NOP_INSTR, 32'h0000_0013, instruction injected into IF/ID on flush or reset (addi x0,x0,0).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ld_valid  in  1  loader word valid.
- ld_ready  out  1  loader may write; high only in LOAD.
- ld_addr  in  32  loader byte address.
- ld_data  in  32  loader word.
- ld_last  in  1  final loader word; qualified by the handshake.
- mem_we  out  1  instruction memory write enable.
- mem_addr  out  AW  memory word index: loader address in LOAD, else pc[AW+1:2].
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  asynchronous read data for mem_addr.
- stall  in  1  hazard unit: hold PC and IF/ID.
- redirect_valid  in  1  taken branch or jump.
- redirect_pc  in  32  redirect target byte address.
- halt_req  in  1  stop fetching (ecall or debug).
- start_load  in  1  in HALT: return to LOAD.
- pc_if  out  32  current fetch PC.
- instr_id  out  32  IF/ID instruction.
- pc_id  out  32  IF/ID PC.
- id_valid  out  1  IF/ID holds a real instruction.
- running  out  1  state is RUN.
- fault  out  1  sticky: misaligned or out-of-range fetch or load.

Behaviour:
- Reset values (asynchronous, active-low):
  - state = LOAD; pc_if = RESET_PC; instr_id = NOP_INSTR; pc_id = 0; id_valid = 0; fault = 0.
  - mem_we = 0 while rst_n is low.
- States: LOAD, RUN, HALT.
- LOAD:
  - ld_ready = 1; mem_we = ld_valid & ld_ready (combinational); mem_addr = ld_addr[AW+1:2]; mem_wdata = ld_data.
  - Word is dropped (mem_we = 0, fault set) if ld_addr[1:0] != 0 or ld_addr >= DEPTH*4.
  - ld_valid & ld_last: that word is written, then RUN next cycle with pc_if = RESET_PC and id_valid = 0.
  - A dropped final word still ends LOAD.
- RUN:
  - ld_ready = 0, mem_we = 0.
  - Priority, highest first: halt_req > redirect_valid > fault fetch > stall > normal.
  - halt_req: go to HALT; id_valid <= 0; instr_id <= NOP_INSTR; pc_if holds.
  - redirect_valid: pc_if <= redirect_pc; id_valid <= 0; instr_id <= NOP_INSTR. Redirect wins over a simultaneous stall (flush).
  - Fault fetch (pc_if[1:0] != 0 or pc_if >= DEPTH*4): go to HALT; fault <= 1; id_valid <= 0.
  - stall: pc_if, instr_id, pc_id and id_valid all hold.
  - Normal: instr_id <= mem_rdata; pc_id <= pc_if; id_valid <= 1; pc_if <= pc_if + 4 (32-bit, wrap ignored because of the range check).
  - Fetch latency: instruction at pc_if appears on instr_id one cycle later.
- HALT:
  - All IF/ID outputs hold; id_valid = 0.
  - start_load: go to LOAD; fault is cleared.
  - redirect, stall and ld_valid are ignored.
- Reset asserted mid-LOAD or mid-RUN: immediate return to reset values. Memory contents are not cleared by this block.
- running = (state == RUN).

Decomposition:
- Shared package (core_pkg): state encoding {LOAD, RUN, HALT}, NOP_INSTR, XLEN = 32, PC increment constant 4.
- One sub-module, if_id_reg: stall, flush and NOP-inject pipeline register. The FSM and PC logic stay in the top module.

Test Plan:
- Load and run: load 4 words at addresses 0, 4, 8, 12 with ld_last on 12 -> mem_we pulses 4 times; running rises next cycle; instr_id shows word 0..3 on consecutive cycles; pc_id = 0, 4, 8, 12.
- Stall: in RUN at pc_if = 8, hold stall for 2 cycles -> pc_if stays 8 and instr_id/pc_id unchanged; after release, pc_id = 8 on the next cycle.
- Redirect: redirect_valid with redirect_pc = 4 together with stall -> next cycle pc_if = 4, id_valid = 0, instr_id = 32'h13; following cycle pc_id = 4.
- Bad load: ld_addr = 256 with DEPTH = 64, then ld_addr = 6 -> mem_we = 0 for both; fault = 1.
- Fetch overrun: redirect_pc = 252, run 2 cycles -> word 63 is fetched; pc_if = 256 triggers HALT with fault = 1 and id_valid = 0; start_load -> LOAD with fault = 0.
- Reset mid-RUN: drop rst_n asynchronously between clock edges -> outputs return to reset values immediately; state is LOAD with ld_ready = 1.
